riscv_aes_mem_wr: RTL and testbench
===================================

RISCV_AES_MEM_WR -- requirements
Module: riscv_aes_mem_wr

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bus data width; block width is 4*DATA_WIDTH.
REQ-002 Parameter DEPTH, default 2: number of 128-bit block buffer entries (power of 2, min 2).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: start_aes_wb  in  1  one-cycle valid pulse from cipher stage.
REQ-007 Port: address_in  in  32  destination byte address of block.
REQ-008 Port: data_in  in  128  ciphered block; [127:96] is word 0.
REQ-009 Port: data_req_o  out  1  bus request.
REQ-010 Port: data_gnt_i  in  1  bus grant.
REQ-011 Port: data_rvalid_i  in  1  write response.
REQ-012 Port: data_addr_o  out  32  word address.
REQ-013 Port: data_we_o  out  1  write enable.
REQ-014 Port: data_be_o  out  4  byte enables.
REQ-015 Port: data_wdata_o  out  32  write data.
REQ-016 Port: halt_en_o  out  1  core stall request.
REQ-017 Port: done_o  out  1  one-cycle pulse, block fully written.
REQ-018 Port: overflow_o  out  1  sticky, block dropped.

Function
REQ-019 start_aes_wb SHALL push {address_in, data_in} into the FIFO if not full; no backpressure exists.
REQ-020 A push when full SHALL be dropped and set overflow_o; overflow_o stays high until rst.
REQ-021 A push and a pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-022 Pop SHALL occur in the cycle the 4th rvalid of the head block is seen.
REQ-023 FSM states: IDLE, REQ, WAIT. IDLE->REQ when FIFO non-empty. REQ->WAIT on data_gnt_i. WAIT->REQ on data_rvalid_i if word<3. WAIT->IDLE on rvalid at word 3, or WAIT->REQ if the FIFO still holds another block.
REQ-024 data_req_o SHALL be high only in REQ; addr, wdata, we and be SHALL be stable from req rise until gnt.
REQ-025 Word n (0..3): data_addr_o = {address_in[31:2],2'b00} + 4*n, modulo 2^32 (wraps); data_wdata_o = data_in[127-32n -: 32]; data_we_o=1; data_be_o=4'hF.
REQ-026 Only one transaction SHALL be outstanding; a new req is not issued before the prior rvalid.
REQ-027 Minimum latency from push to first req SHALL be 1 cycle; with gnt and rvalid zero-wait, a block completes in 8 cycles.
REQ-028 rvalid in IDLE/REQ SHALL be ignored.
REQ-029 done_o SHALL pulse 1 cycle coincident with the pop.
REQ-030 halt_en_o SHALL be high while the FIFO is non-empty or the FSM is not IDLE, and SHALL assert combinationally in the push cycle.

Reset
REQ-031 rst SHALL empty the FIFO, set state IDLE and word=0, and drive all outputs to 0 (data_be_o=0), including mid-transaction; the in-flight block is lost.
REQ-032 A push coincident with rst SHALL be ignored.

Structure
REQ-033 The FSM state enum, WORDS_PER_BLOCK=4 and BLOCK_WIDTH=128 SHALL reside in shared package riscv_aes_pkg.
REQ-034 The buffer SHALL be a sub-module riscv_aes_blk_fifo (push/pop/full/empty, DEPTH param); the FSM and datapath stay in the top module.

Verification
REQ-035 Single block: push addr 0x01234567, data {deadbeef,deafbabe,00000000,cafeface}, zero-wait bus -> writes 0x01234564/deadbeef, ...568/deafbabe, ...56C/00000000, ...570/cafeface; done_o at cycle 8; halt_en_o falls after.
REQ-036 Grant stall: hold gnt low 5 cycles on word 1 -> req, addr and wdata held constant; no second request issued.
REQ-037 Overflow: 3 pushes on consecutive cycles with gnt=0 -> 3rd dropped, overflow_o=1; 2 blocks written after gnt released.
REQ-038 Full+pop: FIFO full, push in the 4th-rvalid cycle -> accepted, overflow_o stays 0, 3 blocks written.
REQ-039 Wrap: addr 0xFFFFFFF8 -> writes to FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-040 Reset mid-op: rst asserted in WAIT of word 2 -> all outputs 0 next cycle; FIFO empty; a subsequent push is written cleanly.

Source files
------------

// File: rtl/riscv_aes_pkg.sv
// Shared definitions for the AES write-back path: block geometry and the
// bus-writer FSM state encoding.
package riscv_aes_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLOCK_WIDTH     = 128;
    localparam int unsigned ADDR_WIDTH      = 32;

    // Bus writer states: idle, request outstanding, waiting for write response.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } wr_state_e;

    // Word-aligned address of word idx within a block; wraps modulo 2^32.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [1:0]            idx
    );
        logic [ADDR_WIDTH-1:0] offset;
        offset = {{(ADDR_WIDTH-4){1'b0}}, idx, 2'b00};
        return {base[ADDR_WIDTH-1:2], 2'b00} + offset;
    endfunction

endpackage

// File: rtl/riscv_aes_blk_fifo.sv
// Small synchronous FIFO holding {address, block} entries awaiting write-back.
// A push while full succeeds only if a pop happens in the same cycle.
module riscv_aes_blk_fifo #(
    parameter int unsigned WIDTH = 160,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    // Full-and-popping frees the head slot this cycle, so the push may land.
    assign push_ok = push && (!full || pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/riscv_aes_mem_wr.sv
// Writes ciphered 128-bit blocks to memory as four 32-bit bus stores, one
// transaction outstanding at a time, buffering blocks in a small FIFO.
module riscv_aes_mem_wr
    import riscv_aes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_aes_wb,
    input  logic [31:0]                address_in,
    input  logic [4*DATA_WIDTH-1:0]    data_in,
    output logic                       data_req_o,
    input  logic                       data_gnt_i,
    input  logic                       data_rvalid_i,
    output logic [31:0]                data_addr_o,
    output logic                       data_we_o,
    output logic [3:0]                 data_be_o,
    output logic [DATA_WIDTH-1:0]      data_wdata_o,
    output logic                       halt_en_o,
    output logic                       done_o,
    output logic                       overflow_o
);

    localparam int unsigned BlkW     = WORDS_PER_BLOCK * DATA_WIDTH;
    localparam int unsigned EntW     = ADDR_WIDTH + BlkW;
    localparam int unsigned CntW     = $clog2(DEPTH) + 1;
    localparam logic [1:0]  LastWord = 2'(WORDS_PER_BLOCK - 1);

    wr_state_e        state_q, state_d;
    logic [1:0]       word_q, word_d;
    logic             overflow_q, overflow_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CntW-1:0]  fifo_count;
    logic [EntW-1:0]  head;
    logic [31:0]      head_addr;
    logic [BlkW-1:0]  head_data;
    logic [BlkW-1:0]  head_shifted;

    // A push coincident with reset is ignored.
    assign push = start_aes_wb && !rst;
    // The head block retires on the response to its last word.
    assign pop  = !rst && (state_q == StWait) && data_rvalid_i && (word_q == LastWord);

    assign head_addr = head[EntW-1 -: ADDR_WIDTH];
    assign head_data = head[BlkW-1:0];

    riscv_aes_blk_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_blk_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({address_in, data_in}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state: bus handshake sequencing, word index and sticky overflow.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                // Also leave on the push itself for one-cycle push-to-request.
                if (!fifo_empty || push) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (data_gnt_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (data_rvalid_i) begin
                    word_d = word_q + 2'd1;
                    if (word_q != LastWord) begin
                        state_d = StReq;
                    end else if ((fifo_count > CntW'(1)) || push) begin
                        // Another block remains after this pop.
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    // Bus outputs: held from the head entry and word index while busy, else zero.
    always_comb begin
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        head_shifted = head_data << (DATA_WIDTH * int'(word_q));
        if (state_q != StIdle) begin
            data_req_o   = (state_q == StReq);
            data_addr_o  = word_addr(head_addr, word_q);
            data_we_o    = 1'b1;
            data_be_o    = 4'hF;
            data_wdata_o = head_shifted[BlkW-1 -: DATA_WIDTH];
        end
    end

    assign halt_en_o  = !fifo_empty || (state_q != StIdle) || push;
    assign done_o     = pop;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_riscv_aes_mem_wr.sv
// Scoreboard bench: stimulus/bus-responder pushes expected per-cycle status and
// expected bus writes into queues; a negedge monitor pops and compares.
module tb_riscv_aes_mem_wr;

    localparam int DEPTH = 2;

    logic         clk;
    logic         rst;
    logic         start_aes_wb;
    logic [31:0]  address_in;
    logic [127:0] data_in;
    logic         data_req_o;
    logic         data_gnt_i;
    logic         data_rvalid_i;
    logic [31:0]  data_addr_o;
    logic         data_we_o;
    logic [3:0]   data_be_o;
    logic [31:0]  data_wdata_o;
    logic         halt_en_o;
    logic         done_o;
    logic         overflow_o;

    riscv_aes_mem_wr #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_aes_wb  (start_aes_wb),
        .address_in    (address_in),
        .data_in       (data_in),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .halt_en_o     (halt_en_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    typedef struct {
        bit   chk;
        bit   all_zero;
        logic done;
        logic halt;
        logic ovf;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          push_cyc = 0;
    int          done_cyc = -1;
    int          n_writes = 0;
    int unsigned gnt_pct = 100;
    int unsigned rv_pct = 100;
    int unsigned noise_pct = 0;

    // Reference model state
    int occ = 0;
    int acked = 0;
    bit outstanding = 0;
    bit ovf_m = 0;
    bit prev_rst = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus bus response; model updates expectations.
    task automatic cycle(input logic st, input logic [31:0] a, input logic [127:0] d,
                         input logic r);
        exp_t e;
        wr_t  w;
        bit   completing;
        bit   acc;
        start_aes_wb = st;
        address_in   = a;
        data_in      = d;
        rst          = r;
        if (r) begin
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
        end else begin
            data_gnt_i    = ($urandom_range(99) < gnt_pct);
            data_rvalid_i = outstanding ? ($urandom_range(99) < rv_pct)
                                        : ($urandom_range(99) < noise_pct);
        end
        completing = !r && outstanding && data_rvalid_i && (acked == 3);
        acc        = st && !r && ((occ < DEPTH) || completing);
        e.chk      = !r;
        e.all_zero = prev_rst && !r && !st;
        e.done     = completing;
        e.halt     = (occ > 0) || (st && !r);
        e.ovf      = ovf_m;
        exp_q.push_back(e);
        if (st) push_cyc = cyc;
        if (acc) begin
            for (int n = 0; n < 4; n++) begin
                w.addr  = (a & 32'hFFFF_FFFC) + 32'(4 * n);
                w.wdata = 32'(d >> (32 * (3 - n)));
                wr_q.push_back(w);
            end
        end
        if (st && !r && !acc) ovf_m = 1'b1;
        if (!r && outstanding && data_rvalid_i) begin
            acked       = (acked + 1) % 4;
            outstanding = 1'b0;
        end else if (!r && data_req_o === 1'b1 && data_gnt_i) begin
            outstanding = 1'b1;
        end
        occ = occ + int'(acc) - int'(completing);
        if (r) begin
            occ         = 0;
            ovf_m       = 1'b0;
            outstanding = 1'b0;
            acked       = 0;
            wr_q.delete();
        end
        prev_rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 128'h0, 1'b0);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (occ > 0 && i < 3000) begin
            cycle(1'b0, 32'h0, 128'h0, 1'b0);
            i++;
        end
        idle(1);
        check({name, "_halt_low"}, 160'(halt_en_o), 160'(0));
        check({name, "_writes_left"}, 160'(wr_q.size()), 160'(0));
    endtask

    // Monitor: per-cycle status, bus writes, hold-until-grant, single outstanding.
    initial begin
        exp_t e;
        wr_t  w;
        bit   prev_stall;
        bit   mon_out;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        prev_stall = 1'b0;
        mon_out    = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("done", 160'(done_o), 160'(e.done));
                    check("halt", 160'(halt_en_o), 160'(e.halt));
                    check("overflow", 160'(overflow_o), 160'(e.ovf));
                end
                if (e.all_zero) begin
                    check("outputs_zero_after_reset",
                          160'({data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
                                done_o, halt_en_o, overflow_o}), 160'(0));
                end
            end
            if (done_o === 1'b1) done_cyc = cyc;
            if (rst !== 1'b1 && data_req_o === 1'b1 && data_gnt_i === 1'b1) begin
                n_writes++;
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h, expected no write",
                             data_addr_o);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 160'(data_addr_o), 160'(w.addr));
                    check("wr_data", 160'(data_wdata_o), 160'(w.wdata));
                    check("wr_we_be", 160'({data_we_o, data_be_o}), 160'(5'h1F));
                end
            end
            if (rst !== 1'b1 && prev_stall) begin
                check("hold_req_addr_data", 160'({data_req_o, data_addr_o, data_wdata_o}),
                      160'({1'b1, prev_addr, prev_wdata}));
            end
            if (rst !== 1'b1 && mon_out && data_req_o === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL second_outstanding: got req=1, expected 0 before rvalid");
            end
            prev_stall = (rst !== 1'b1) && (data_req_o === 1'b1) && (data_gnt_i === 1'b0);
            prev_addr  = data_addr_o;
            prev_wdata = data_wdata_o;
            if (rst === 1'b1) mon_out = 1'b0;
            else if (mon_out && data_rvalid_i === 1'b1) mon_out = 1'b0;
            else if (data_req_o === 1'b1 && data_gnt_i === 1'b1) mon_out = 1'b1;
        end
    end

    initial begin
        int w0;
        start_aes_wb  = 1'b0;
        address_in    = '0;
        data_in       = '0;
        rst           = 1'b1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b0, 32'h0, 128'h0, 1'b1);
        cycle(1'b0, 32'h0, 128'h0, 1'b1);
        idle(1);

        // Single block, zero-wait bus: done eight cycles after the push
        cycle(1'b1, 32'h0123_4567,
              128'hdeadbeef_deafbabe_00000000_cafeface, 1'b0);
        idle(12);
        check("single_done_latency", 160'(done_cyc - push_cyc), 160'(8));
        check("single_writes", 160'(n_writes), 160'(4));

        // Address wrap across 2^32
        cycle(1'b1, 32'hFFFF_FFF8, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain("wrap");

        // Overflow: three back-to-back pushes with no grant
        w0 = n_writes;
        gnt_pct = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        idle(3);
        check("overflow_set", 160'(overflow_o), 160'(1));
        gnt_pct = 100;
        drain("overflow");
        check("overflow_writes", 160'(n_writes - w0), 160'(8));
        check("overflow_sticky", 160'(overflow_o), 160'(1));
        cycle(1'b0, 32'h0, 128'h0, 1'b1);
        idle(1);

        // Full FIFO with a push in the pop cycle
        w0 = n_writes;
        cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(6);
        cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain("full_pop");
        check("full_pop_no_overflow", 160'(overflow_o), 160'(0));
        check("full_pop_writes", 160'(n_writes - w0), 160'(12));

        // Grant stall on word 1
        cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(2);
        gnt_pct = 0;
        idle(5);
        gnt_pct = 100;
        drain("gnt_stall");

        // Reset in WAIT of word 2, with a push that must be ignored
        cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(5);
        cycle(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        idle(1);
        w0 = n_writes;
        cycle(1'b1, 32'h0000_1000, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain("after_reset");
        check("after_reset_writes", 160'(n_writes - w0), 160'(4));

        // Randomised traffic with bus stalls and stray responses
        gnt_pct   = 60;
        rv_pct    = 60;
        noise_pct = 30;
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(99) < 20), $urandom,
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
